// File: rtl/turbo_iter_sched.sv
// Turbo decoder iteration scheduler: alternates one SISO between DEC1/DEC2 half-iterations,
// counts iterations, latches hard decisions, watchdogs the SISO. Define EARLY_STOP_EN for early stop.
module turbo_iter_sched #(
  parameter int MAX_ITER = 16,
  parameter int ITER_W   = 5,
  parameter int HD_W     = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [ITER_W-1:0] iter_limit_i,
  output logic              siso_start_o,
  input  logic              siso_done_i,
  output logic              half_sel_o,
  output logic              ext_clr_o,
  output logic              ext_we_o,
  input  logic [HD_W-1:0]   hd_i,
  output logic [HD_W-1:0]   hd_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH1 = 3'd1,
    S_WAIT1   = 3'd2,
    S_LAUNCH2 = 3'd3,
    S_WAIT2   = 3'd4,
    S_CHECK   = 3'd5,
    S_FIN     = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [HD_W-1:0]   hd_q, hd_d;
  logic              siso_start_q, siso_start_d;
  logic              half_sel_q, half_sel_d;
  logic              ext_clr_q, ext_clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef EARLY_STOP_EN
  logic [HD_W-1:0]   hist_q, hist_d;
`endif

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      iter_q       <= '0;
      limit_q      <= '0;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      hd_q         <= '0;
      siso_start_q <= 1'b0;
      half_sel_q   <= 1'b0;
      ext_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef EARLY_STOP_EN
      hist_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      limit_q      <= limit_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
      hd_q         <= hd_d;
      siso_start_q <= siso_start_d;
      half_sel_q   <= half_sel_d;
      ext_clr_q    <= ext_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef EARLY_STOP_EN
      hist_q       <= hist_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    limit_d = limit_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    hd_d    = hd_q;
`ifdef EARLY_STOP_EN
    hist_d  = hist_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LAUNCH1;
          limit_d = (iter_limit_i == '0) ? ITER_W'(MAX_ITER) : iter_limit_i;
          iter_d  = '0;
          err_d   = 1'b0;
`ifdef EARLY_STOP_EN
          hist_d  = '0;
`endif
        end
      end
      S_LAUNCH1: begin
        state_d = S_WAIT1;
        wdog_d  = '0;
      end
      S_LAUNCH2: begin
        state_d = S_WAIT2;
        wdog_d  = '0;
      end
      S_WAIT1, S_WAIT2: begin
        // A done arriving in the expiry cycle takes priority over the timeout.
        if (siso_done_i) begin
          wdog_d = '0;
          if (state_q == S_WAIT1) begin
            state_d = S_LAUNCH2;
          end else begin
            state_d = S_CHECK;
            iter_d  = (iter_q == {ITER_W{1'b1}}) ? iter_q : iter_q + ITER_W'(1);
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          wdog_d  = '0;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_CHECK: begin
`ifdef EARLY_STOP_EN
        hist_d = hd_i;
        if (iter_q == limit_q) begin
          state_d = S_FIN;
        end else if ((iter_q >= ITER_W'(2)) && (hd_i == hist_q)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_LAUNCH1;
        end
`else
        state_d = (iter_q == limit_q) ? S_FIN : S_LAUNCH1;
`endif
      end
      S_FIN: begin
        hd_d    = hd_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    siso_start_d = (state_d == S_LAUNCH1) || (state_d == S_LAUNCH2);
    half_sel_d   = (state_d == S_LAUNCH2) || (state_d == S_WAIT2);
    ext_clr_d    = ((state_d == S_LAUNCH1) || (state_d == S_WAIT1)) && (iter_d == '0);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
  end

  assign ext_we_o     = siso_done_i && ((state_q == S_WAIT1) || (state_q == S_WAIT2));
  assign siso_start_o = siso_start_q;
  assign half_sel_o   = half_sel_q;
  assign ext_clr_o    = ext_clr_q;
  assign hd_o         = hd_q;
  assign iter_cnt_o   = iter_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_turbo_iter_sched.sv
// Bench for turbo_iter_sched: randomized decodes with a SISO responder, expected outcomes
// queued per decode and checked by a monitor at each done_o pulse.
module tb_turbo_iter_sched;

  localparam int MAX_ITER = 16;
  localparam int ITER_W   = 5;
  localparam int HD_W     = 5;
  localparam int TIMEOUT  = 255;
`ifdef EARLY_STOP_EN
  localparam bit ES = 1'b1;
`else
  localparam bit ES = 1'b0;
`endif

  logic              clk_p_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ITER_W-1:0] iter_limit_i = '0;
  logic              siso_done_i = 1'b0;
  logic [HD_W-1:0]   hd_i = '0;
  logic              siso_start_o, half_sel_o, ext_clr_o, ext_we_o;
  logic [HD_W-1:0]   hd_o;
  logic [ITER_W-1:0] iter_cnt_o;
  logic              busy_o, done_o, err_o;

  turbo_iter_sched #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .HD_W(HD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_p_i(clk_p_i), .reset_n_i(reset_n_i), .start_i(start_i), .iter_limit_i(iter_limit_i),
    .siso_start_o(siso_start_o), .siso_done_i(siso_done_i), .half_sel_o(half_sel_o),
    .ext_clr_o(ext_clr_o), .ext_we_o(ext_we_o), .hd_i(hd_i), .hd_o(hd_o),
    .iter_cnt_o(iter_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  typedef struct {
    int starts;
    int wes;
    int iters;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Per-decode SISO behaviour, set by the driver before each start.
  int              hang_idx = -1;
  int              slow_idx = -1;
  bit              hd_fixed_en = 1'b0;
  logic [HD_W-1:0] hd_fix = '0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : global_guard
    #800000;
    $display("FAIL global_timeout: simulation did not finish, got 0 required 1");
    $fatal(1, "global timeout");
  end

  initial begin : hd_drive
    forever begin
      @(posedge clk_p_i);
      #1;
      hd_i = hd_fixed_en ? hd_fix : HD_W'($urandom);
    end
  end

  // SISO model: answers each launch after a random latency, can hang or be maximally slow,
  // and injects spurious done pulses whenever no operation is outstanding.
  initial begin : siso_model
    int h = 0;
    int cnt = 0;
    bit hanging = 1'b0;
    bit saw_start, saw_done, in_rst;
    forever begin
      @(negedge clk_p_i);
      saw_start = siso_start_o;
      saw_done  = done_o;
      in_rst    = !reset_n_i;
      @(posedge clk_p_i);
      #1;
      siso_done_i = 1'b0;
      if (in_rst || !reset_n_i) begin
        h = 0; cnt = 0; hanging = 1'b0;
      end else begin
        if (saw_done) begin
          h = 0; cnt = 0; hanging = 1'b0;
        end
        if (saw_start) begin
          if (h == hang_idx) hanging = 1'b1;
          else cnt = (h == slow_idx) ? TIMEOUT : int'($urandom_range(1, 12));
          h++;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) siso_done_i = 1'b1;
        end else if (!hanging && !saw_start && ($urandom_range(0, 7) == 0)) begin
          siso_done_i = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    int starts = 0;
    int wes = 0;
    int cyc = 0;
    int last_start = 0;
    bit pend_hd = 1'b0;
    logic [HD_W-1:0] exp_hd = '0;
    exp_t e;
    forever begin
      @(negedge clk_p_i);
      cyc++;
      if (!reset_n_i) begin
        starts = 0; wes = 0; pend_hd = 1'b0;
      end else begin
        if (pend_hd) begin
          check("hd_o", hd_o, exp_hd);
          check("busy_after_done", busy_o, 0);
          check("done_single", done_o, 0);
          pend_hd = 1'b0;
        end
        if (siso_start_o) begin
          check("half_sel_o", half_sel_o, starts % 2);
          check("ext_clr_launch", ext_clr_o, starts == 0);
          starts++;
          last_start = cyc;
        end else if (busy_o && !done_o) begin
          check("ext_clr_wait", ext_clr_o, (starts == 1) && (wes == 0));
        end
        if (ext_we_o) wes++;
        if (done_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("siso_starts", starts, e.starts);
            check("ext_we_count", wes, e.wes);
            check("iter_cnt_o", iter_cnt_o, e.iters);
            check("err_o", err_o, e.err);
            check("busy_o_fin", busy_o, 1);
            if (e.err) check("timeout_cycles", cyc - last_start, TIMEOUT + 1);
          end
          exp_hd = hd_i;
          pend_hd = 1'b1;
          starts = 0;
          wes = 0;
        end
      end
    end
  end

  function automatic int eff_limit(input int lim);
    return (lim == 0) ? MAX_ITER : lim;
  endfunction

  task automatic launch(input int lim, input int hang, input int slow, input bit fixed,
                        input logic [HD_W-1:0] hv);
    exp_t e;
    int L, its, halves;
    L = eff_limit(lim);
    its = (ES && fixed && (L >= 2)) ? 2 : L;
    halves = 2 * its;
    if (hang >= 0 && hang < halves) begin
      e.starts = hang + 1; e.wes = hang; e.iters = hang / 2; e.err = 1'b1;
    end else begin
      e.starts = halves; e.wes = halves; e.iters = its; e.err = 1'b0;
    end
    hang_idx = hang;
    slow_idx = slow;
    hd_fixed_en = fixed;
    hd_fix = hv;
    exp_q.push_back(e);
    @(posedge clk_p_i);
    #1;
    start_i = 1'b1;
    iter_limit_i = ITER_W'(lim);
    @(posedge clk_p_i);
    #1;
    start_i = 1'b0;
    iter_limit_i = ITER_W'($urandom);
    @(negedge clk_p_i);
    check("start_latency", siso_start_o, 1);
  endtask

  task automatic run_decode(input int lim, input int hang, input int slow, input bit fixed,
                            input logic [HD_W-1:0] hv);
    bit finished = 1'b0;
    bit prev_ok;
    launch(lim, hang, slow, fixed, hv);
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk_p_i);
      if (!busy_o) begin
        finished = 1'b1;
        break;
      end
      prev_ok = busy_o && !done_o;
      @(posedge clk_p_i);
      #1;
      start_i = prev_ok && ($urandom_range(0, 4) == 0);
      iter_limit_i = ITER_W'($urandom);
    end
    start_i = 1'b0;
    if (!finished) check("decode_finished", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_siso_start_o"}, siso_start_o, 0);
    check({tag, "_half_sel_o"}, half_sel_o, 0);
    check({tag, "_ext_clr_o"}, ext_clr_o, 0);
    check({tag, "_ext_we_o"}, ext_we_o, 0);
    check({tag, "_hd_o"}, hd_o, 0);
    check({tag, "_iter_cnt_o"}, iter_cnt_o, 0);
    check({tag, "_busy_o"}, busy_o, 0);
    check({tag, "_done_o"}, done_o, 0);
    check({tag, "_err_o"}, err_o, 0);
  endtask

  task automatic mid_decode_reset();
    int seen = 0;
    bit reached = 1'b0;
    launch(5, -1, -1, ES, HD_W'($urandom));
    seen = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_p_i);
      if (siso_start_o) seen++;
      if (seen == 3) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) check("reach_iter2_launch1", 0, 1);
    @(negedge clk_p_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_p_i);
  endtask

  initial begin : stimulus
    int lim, L, hang, slow;
    bit fixed;
    repeat (3) @(posedge clk_p_i);
    @(negedge clk_p_i);
    check_all_zero("reset");
    @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b1;

    run_decode(0, -1, -1, ES, 5'b01001);
    run_decode(3, -1, -1, ES, 5'b11100);
    run_decode(8, -1, -1, 1'b1, 5'b10110);
    run_decode(4, 1, -1, ES, 5'b00111);
    run_decode(2, -1, -1, ES, 5'b01010);
    run_decode(4, 0, -1, ES, 5'b10001);
    run_decode(2, -1, 1, ES, 5'b11111);
    run_decode(31, -1, -1, ES, 5'b00011);
    run_decode(1, -1, -1, ES, 5'b01100);
    mid_decode_reset();
    run_decode(2, -1, -1, ES, 5'b10101);

    for (int n = 0; n < 20; n++) begin
      lim = $urandom_range(0, 31);
      L = eff_limit(lim);
      hang = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2 * L - 1)) : -1;
      slow = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      fixed = ES ? 1'b1 : 1'(($urandom_range(0, 1)));
      run_decode(lim, hang, slow, fixed, HD_W'($urandom));
    end

    repeat (3) @(negedge clk_p_i);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
